// File: rtl/reg_scoreboard.sv
// Register scoreboard for the decode stage: counts in-flight writers per
// architectural register and reports RAW stalls for each source read port.
module reg_scoreboard #(
    parameter int NREG      = 32,
    parameter int AW        = 5,
    parameter int NRP       = 2,
    parameter int CNT_W     = 2,
    parameter int WB_BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              issue_valid,
    input  logic              issue_we,
    input  logic [AW-1:0]     issue_dest,
    output logic              issue_full,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_dest,
    input  logic [NRP*AW-1:0] rd_addr,
    input  logic [NRP-1:0]    rd_need,
    output logic [NRP-1:0]    rd_busy,
    output logic              stall,
    output logic [NREG-1:0]   busy_vec,
    output logic              err
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // Register 0 has no storage; w_cnt presents it as a constant zero entry.
    logic [NREG-1:1][CNT_W-1:0] r_cnt;
    logic [NREG-1:1][CNT_W-1:0] w_cnt_nxt;
    logic [NREG-1:0][CNT_W-1:0] w_cnt;
    logic                       r_err;
    logic                       w_err_nxt;
    logic [NREG-1:0]            w_inc_oh;
    logic [NREG-1:0]            w_dec_oh;
    logic                       w_ovf;
    logic                       w_unf;
    logic [NRP-1:0][CNT_W-1:0]  w_rd_cnt;
    logic [NRP-1:0]             w_rd_rel;
    logic [CNT_W-1:0]           w_iss_cnt;

    // Addresses that match no implemented register (0 or >= NREG) read as zero.
    function automatic logic [CNT_W-1:0] cnt_of(
        input logic [AW-1:0]                addr,
        input logic [NREG-1:0][CNT_W-1:0]   cnts
    );
        logic [CNT_W-1:0] v;
        v = CNT_ZERO;
        for (int r = 1; r < NREG; r++) begin
            v = v | ({CNT_W{addr == AW'(r)}} & cnts[r]);
        end
        return v;
    endfunction

    assign w_cnt = {r_cnt, CNT_ZERO};
    assign err   = r_err;

    // One-hot decode of issue and writeback destinations.
    always_comb begin
        w_inc_oh = {NREG{1'b0}};
        w_dec_oh = {NREG{1'b0}};
        for (int r = 1; r < NREG; r++) begin
            w_inc_oh[r] = issue_valid && issue_we && (issue_dest == AW'(r));
            w_dec_oh[r] = wb_valid && (wb_dest == AW'(r));
        end
    end

    // Counter next-state; a simultaneous issue and writeback cancel out.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_ovf     = 1'b0;
        w_unf     = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            if (flush) begin
                w_cnt_nxt[r] = CNT_ZERO;
            end else if (w_inc_oh[r] && !w_dec_oh[r]) begin
                if (r_cnt[r] == CNT_MAX) begin
                    w_ovf = 1'b1;
                end else begin
                    w_cnt_nxt[r] = r_cnt[r] + CNT_ONE;
                end
            end else if (w_dec_oh[r] && !w_inc_oh[r]) begin
                if (r_cnt[r] == CNT_ZERO) begin
                    w_unf = 1'b1;
                end else begin
                    w_cnt_nxt[r] = r_cnt[r] - CNT_ONE;
                end
            end else begin
                w_cnt_nxt[r] = r_cnt[r];
            end
        end
        if (flush) begin
            w_err_nxt = r_err;
        end else begin
            w_err_nxt = r_err | w_ovf | w_unf;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= {((NREG-1)*CNT_W){1'b0}};
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_err <= w_err_nxt;
        end
    end

    // Per-port RAW stall; the last writer committing this cycle may release it.
    always_comb begin
        rd_busy  = {NRP{1'b0}};
        w_rd_cnt = {(NRP*CNT_W){1'b0}};
        w_rd_rel = {NRP{1'b0}};
        for (int i = 0; i < NRP; i++) begin
            w_rd_cnt[i] = cnt_of(rd_addr[i*AW +: AW], w_cnt);
            w_rd_rel[i] = (WB_BYPASS != 0) && wb_valid
                          && (wb_dest == rd_addr[i*AW +: AW])
                          && (w_rd_cnt[i] == CNT_ONE);
            rd_busy[i]  = rd_need[i] && (w_rd_cnt[i] != CNT_ZERO) && !w_rd_rel[i];
        end
    end

    // Issue saturation check and combined decode stall.
    always_comb begin
        w_iss_cnt  = cnt_of(issue_dest, w_cnt);
        issue_full = (w_iss_cnt == CNT_MAX) && !(wb_valid && (wb_dest == issue_dest));
        stall      = (|rd_busy) || (issue_we && issue_full);
    end

    // Busy summary, one bit per architectural register.
    always_comb begin
        busy_vec = {NREG{1'b0}};
        for (int r = 0; r < NREG; r++) begin
            busy_vec[r] = (w_cnt[r] != CNT_ZERO);
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus randomized
// traffic compared against a per-register counter model.
module tb_reg_scoreboard;

    localparam int NREG  = 32;
    localparam int AW    = 5;
    localparam int NRP   = 2;
    localparam int CNT_W = 2;
    localparam int MAXC  = 3;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              issue_valid;
    logic              issue_we;
    logic [AW-1:0]     issue_dest;
    logic              issue_full;
    logic              wb_valid;
    logic [AW-1:0]     wb_dest;
    logic [NRP*AW-1:0] rd_addr;
    logic [NRP-1:0]    rd_need;
    logic [NRP-1:0]    rd_busy;
    logic              stall;
    logic [NREG-1:0]   busy_vec;
    logic              err;

    int total = 0;
    int bad   = 0;

    int m_cnt [NREG];
    bit m_err;

    reg_scoreboard #(
        .NREG(NREG), .AW(AW), .NRP(NRP), .CNT_W(CNT_W), .WB_BYPASS(1)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_dest(issue_dest),
        .issue_full(issue_full), .wb_valid(wb_valid), .wb_dest(wb_dest),
        .rd_addr(rd_addr), .rd_need(rd_need), .rd_busy(rd_busy),
        .stall(stall), .busy_vec(busy_vec), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush       = 1'b0;
        issue_valid = 1'b0;
        issue_we    = 1'b0;
        issue_dest  = 5'd0;
        wb_valid    = 1'b0;
        wb_dest     = 5'd0;
        rd_addr     = 10'd0;
        rd_need     = 2'b00;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] d);
        idle();
        issue_valid = 1'b1;
        issue_we    = 1'b1;
        issue_dest  = d;
        tick();
        idle();
    endtask

    task automatic wb(input logic [AW-1:0] d);
        idle();
        wb_valid = 1'b1;
        wb_dest  = d;
        tick();
        idle();
    endtask

    function automatic int mc(input int a);
        if (a <= 0 || a >= NREG) return 0;
        return m_cnt[a];
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick();
        #3;
        total++; if (busy_vec !== 32'd0) begin bad++; $display("FAIL reset_busy_vec: got %h want 0", busy_vec); end
        total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL reset_rd_busy: got %b want 00", rd_busy); end
        total++; if (issue_full !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL reset_full_stall: got %b%b want 00", issue_full, stall); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        issue(5'd5);
        rd_addr = {5'd0, 5'd5};
        rd_need = 2'b01;
        #3;
        total++; if (rd_busy !== 2'b01) begin bad++; $display("FAIL basic_busy: got %b want 01", rd_busy); end
        total++; if (busy_vec[5] !== 1'b1 || stall !== 1'b1) begin bad++; $display("FAIL basic_vec_stall: got %b%b want 11", busy_vec[5], stall); end
        wb_valid = 1'b1;
        wb_dest  = 5'd5;
        #1;
        total++; if (rd_busy !== 2'b00 || stall !== 1'b0) begin bad++; $display("FAIL basic_bypass: got %b/%b want 00/0", rd_busy, stall); end
        tick();
        wb_valid = 1'b0;
        #3;
        total++; if (busy_vec !== 32'd0 || rd_busy !== 2'b00) begin bad++; $display("FAIL basic_release: got %h/%b want 0/00", busy_vec, rd_busy); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(5'd3);
        issue(5'd3);
        rd_addr  = {5'd3, 5'd0};
        rd_need  = 2'b10;
        wb_valid = 1'b1;
        wb_dest  = 5'd3;
        #3;
        total++; if (rd_busy !== 2'b10) begin bad++; $display("FAIL b2b_cnt2_wb: got %b want 10", rd_busy); end
        tick();
        wb_valid = 1'b0;
        #3;
        total++; if (rd_busy !== 2'b10) begin bad++; $display("FAIL b2b_cnt1: got %b want 10", rd_busy); end
        wb_valid = 1'b1;
        #1;
        total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL b2b_last_wb: got %b want 00", rd_busy); end
        tick();
        wb_valid = 1'b0;
        #3;
        total++; if (busy_vec !== 32'd0 || err !== 1'b0) begin bad++; $display("FAIL b2b_done: got %h/%b want 0/0", busy_vec, err); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        issue(5'd7);
        issue_valid = 1'b1;
        issue_we    = 1'b1;
        issue_dest  = 5'd7;
        wb_valid    = 1'b1;
        wb_dest     = 5'd7;
        #3;
        total++; if (issue_full !== 1'b0) begin bad++; $display("FAIL same_full: got %b want 0", issue_full); end
        tick();
        idle();
        rd_addr = {5'd0, 5'd7};
        rd_need = 2'b01;
        #3;
        total++; if (rd_busy !== 2'b01 || busy_vec !== 32'h80) begin bad++; $display("FAIL same_keep: got %b/%h want 01/80", rd_busy, busy_vec); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL same_err: got %b want 0", err); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        issue(5'd0);
        rd_addr = {5'd0, 5'd0};
        rd_need = 2'b11;
        #3;
        total++; if (rd_busy !== 2'b00 || busy_vec !== 32'd0) begin bad++; $display("FAIL zero_busy: got %b/%h want 00/0", rd_busy, busy_vec); end
        issue(5'd2);
        rd_addr = {5'd2, 5'd2};
        rd_need = 2'b00;
        #3;
        total++; if (rd_busy !== 2'b00 || stall !== 1'b0) begin bad++; $display("FAIL zero_noneed: got %b/%b want 00/0", rd_busy, stall); end
        total++; if (busy_vec !== 32'h4) begin bad++; $display("FAIL zero_vec2: got %h want 4", busy_vec); end
    endtask

    task automatic test_saturate();
        do_reset();
        issue(5'd9);
        issue(5'd9);
        issue(5'd9);
        issue_we   = 1'b1;
        issue_dest = 5'd9;
        #3;
        total++; if (issue_full !== 1'b1 || stall !== 1'b1) begin bad++; $display("FAIL sat_full: got %b/%b want 1/1", issue_full, stall); end
        issue_dest = 5'd10;
        #1;
        total++; if (issue_full !== 1'b0) begin bad++; $display("FAIL sat_other: got %b want 0", issue_full); end
        issue_dest = 5'd9;
        wb_valid   = 1'b1;
        wb_dest    = 5'd9;
        #1;
        total++; if (issue_full !== 1'b0) begin bad++; $display("FAIL sat_wb_relief: got %b want 0", issue_full); end
        issue(5'd9);
        #3;
        total++; if (err !== 1'b1 || busy_vec[9] !== 1'b1) begin bad++; $display("FAIL sat_overflow: got err=%b busy=%b want 1/1", err, busy_vec[9]); end
        wb(5'd9);
        wb(5'd9);
        #3;
        total++; if (busy_vec[9] !== 1'b1) begin bad++; $display("FAIL sat_held3: got %b want 1", busy_vec[9]); end
        wb(5'd9);
        #3;
        total++; if (busy_vec[9] !== 1'b0) begin bad++; $display("FAIL sat_drain: got %b want 0", busy_vec[9]); end
        do_reset();
        wb(5'd0);
        #3;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL wb_r0_err: got %b want 0", err); end
        wb(5'd11);
        #3;
        total++; if (err !== 1'b1 || busy_vec !== 32'd0) begin bad++; $display("FAIL underflow: got %b/%h want 1/0", err, busy_vec); end
    endtask

    task automatic test_flush();
        do_reset();
        wb(5'd12);
        issue(5'd4);
        issue(5'd6);
        #3;
        total++; if (busy_vec !== 32'h50) begin bad++; $display("FAIL flush_pre: got %h want 50", busy_vec); end
        flush    = 1'b1;
        wb_valid = 1'b1;
        wb_dest  = 5'd4;
        tick();
        idle();
        rd_addr = {5'd6, 5'd4};
        rd_need = 2'b11;
        #3;
        total++; if (busy_vec !== 32'd0 || rd_busy !== 2'b00) begin bad++; $display("FAIL flush_clear: got %h/%b want 0/00", busy_vec, rd_busy); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL flush_err_kept: got %b want 1", err); end
        issue(5'd4);
        flush = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        #3;
        total++; if (busy_vec !== 32'd0 || err !== 1'b0) begin bad++; $display("FAIL reset_flush: got %h/%b want 0/0", busy_vec, err); end
    endtask

    task automatic test_random();
        logic [NREG-1:0] e_vec;
        logic [NRP-1:0]  e_busy;
        logic            e_full;
        logic            e_stall;
        int              a;
        int              c;
        do_reset();
        for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
        m_err = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            issue_valid = 1'($urandom_range(0, 1));
            issue_we    = ($urandom_range(0, 3) != 0);
            issue_dest  = AW'($urandom_range(0, 7));
            if (issue_valid && issue_we && mc(int'(issue_dest)) == MAXC && $urandom_range(0, 9) != 0)
                issue_valid = 1'b0;
            wb_valid = 1'($urandom_range(0, 1));
            wb_dest  = AW'($urandom_range(0, 7));
            if (wb_valid && mc(int'(wb_dest)) == 0 && $urandom_range(0, 9) != 0)
                wb_valid = 1'b0;
            flush = ($urandom_range(0, 63) == 0);
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NRP; i++) rd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
            rd_need = NRP'($urandom_range(0, 3));
            #3;
            for (int r = 0; r < NREG; r++) e_vec[r] = (mc(r) != 0);
            for (int i = 0; i < NRP; i++) begin
                a = int'(rd_addr[i*AW +: AW]);
                e_busy[i] = rd_need[i] && (mc(a) != 0)
                            && !(wb_valid && int'(wb_dest) == a && mc(a) == 1);
            end
            e_full  = (mc(int'(issue_dest)) == MAXC) && !(wb_valid && wb_dest == issue_dest);
            e_stall = (|e_busy) || (issue_we && e_full);
            total++; if (busy_vec !== e_vec) begin bad++; $display("FAIL rnd_vec @%0d: got %h want %h", n, busy_vec, e_vec); end
            total++; if (rd_busy !== e_busy) begin bad++; $display("FAIL rnd_busy @%0d: got %b want %b", n, rd_busy, e_busy); end
            total++; if (issue_full !== e_full || stall !== e_stall) begin bad++; $display("FAIL rnd_full_stall @%0d: got %b%b want %b%b", n, issue_full, stall, e_full, e_stall); end
            total++; if (err !== m_err) begin bad++; $display("FAIL rnd_err @%0d: got %b want %b", n, err, m_err); end
            if (reset) begin
                for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
                m_err = 1'b0;
            end else if (flush) begin
                for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
            end else begin
                for (int r = 1; r < NREG; r++) begin
                    c = (issue_valid && issue_we && int'(issue_dest) == r) ? 1 : 0;
                    c = c - ((wb_valid && int'(wb_dest) == r) ? 1 : 0);
                    if (m_cnt[r] + c > MAXC) m_err = 1'b1;
                    else if (m_cnt[r] + c < 0) m_err = 1'b1;
                    else m_cnt[r] = m_cnt[r] + c;
                end
            end
            tick();
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_same_cycle();
        test_zero_reg();
        test_saturate();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Parametrised register scoreboard for the decode stage. It tracks how many in-flight instructions will still write each architectural register, and reports per-read-port RAW stall conditions. Decode issues writers into it; writeback retires them. Decode's ready_go is the inverse of the OR of the port stalls and the issue-full condition. It replaces fixed ES/MS compare-and-stall logic, so pipeline depth and read-port count can change without touching decode.

## Interface
Parameters:
- NREG, 32: number of architectural registers; register 0 is hard-wired zero.
- AW, 5: register address width; requires 2^AW >= NREG.
- NRP, 2: number of source read ports.
- CNT_W, 2: width of each pending counter; maximum in-flight writers per register is 2^CNT_W-1.
- WB_BYPASS, 1: 1 means a same-cycle writeback releases the read stall; 0 means the stall releases one cycle later.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- flush  in  1  clears all counters at the next edge.
- issue_valid  in  1  an instruction leaves decode this cycle (ds_to_es_valid && es_allowin).
- issue_we  in  1  the issuing instruction writes a GPR.
- issue_dest  in  AW  destination of the issuing instruction.
- issue_full  out  1  counter for issue_dest is saturated, so issue is not allowed.
- wb_valid  in  1  a writeback commits this cycle (rf_we && ws valid).
- wb_dest  in  AW  writeback destination.
- rd_addr  in  NRP*AW  source addresses; port i occupies [i*AW +: AW].
- rd_need  in  NRP  port i operand is actually used.
- rd_busy  out  NRP  port i has an outstanding writer, so decode must stall.
- stall  out  1  |rd_busy or (issue_we && issue_full).
- busy_vec  out  NREG  bit r = (cnt[r] != 0).
- err  out  1  sticky protocol error flag.

## Operation
- State:
  - cnt[r], CNT_W bits, for r in 1..NREG-1.
  - cnt[0] is a constant 0, never written.
  - err is one flop.
- Issue increment: inc_r = issue_valid && issue_we && issue_dest==r && r!=0.
- Writeback decrement: dec_r = wb_valid && wb_dest==r && r!=0.
- Per-edge update, in priority order:
  - reset: all cnt = 0, err = 0.
  - flush: all cnt = 0; err is kept.
  - inc_r && dec_r: cnt unchanged.
  - inc_r only: cnt+1. At max it saturates at max and sets err.
  - dec_r only: cnt-1. At 0 it stays 0 and sets err (underflow).
- Flush contract: the exception/ertn path asserts flush only in a cycle where every older in-flight writer is either killed or committing. A writeback in a flush cycle is therefore absorbed by the clear.
- Read stall:
  - rd_busy[i] = rd_need[i] && rd_addr[i]!=0 && cnt[rd_addr[i]]!=0 && !rel_i.
  - rel_i = WB_BYPASS && dec for rd_addr[i] && cnt[rd_addr[i]]==1.
  - With WB_BYPASS=1, decode takes the writeback data through the existing WS-to-DS forward mux.
- issue_full = issue_dest!=0 && cnt[issue_dest]==max && !(wb_valid && wb_dest==issue_dest).
- The block issues no data forwarding and does not know stage positions. Forwarding of ES/MS results stays in decode; it uses busy only to detect when no forward source covers a register.
- Addresses >= NREG are treated as register 0: never busy, never counted.

## Timing
- Reset values:
  - rd_busy = 0, issue_full = 0, stall = 0, busy_vec = 0, err = 0.
  - These hold from the first edge with reset high until the first issue.
- rd_busy, issue_full, stall are combinational from registered cnt plus the same-cycle wb_* and issue_* inputs. No combinational path exists from issue_valid to rd_busy.
- Latency: an issue at edge N makes busy_vec set, and rd_busy asserts for a matching port, from cycle N+1.
- Release latency: a writeback in cycle M releases the stall in cycle M with WB_BYPASS=1, or in cycle M+1 with WB_BYPASS=0.
- Reset mid-operation clears everything in one edge. Flush clears counters in one edge; stalls are gone the next cycle.
- Critical path is an AW:NREG decode, then a CNT_W compare, then an NRP OR; it must fit the decode stage budget.

## Test plan
- Reset, then issue r5 with issue_we=1; next cycle drive rd_addr0=5, rd_need0=1.
  - Required: rd_busy[0]=1, busy_vec[5]=1.
  - After wb_dest=5: rd_busy[0]=0 in the same cycle (WB_BYPASS=1), busy_vec[5]=0 the next cycle.
- Two issues to r3 back-to-back (cnt=2), then one wb to r3.
  - Required: rd_busy stays 1 (cnt=1); it clears only on the second wb.
  - err=0 throughout.
- In one cycle, issue r7 and wb r7 with cnt[7]=1.
  - Required: cnt stays 1, so rd_busy for r7 is 1 the next cycle.
  - issue_full=0 even when CNT_W=1.
- rd_addr=0 with rd_need=1, after issuing dest 0.
  - Required: rd_busy=0, busy_vec=0.
  - rd_need=0 on a busy register also gives rd_busy=0.
- With CNT_W=2, issue r9 three times.
  - Required: issue_full=1 while issue_dest=9.
  - A forced fourth issue leaves cnt=3 and sets err=1.
  - A wb to r0 with counters at 0 does not set err.
- With r4 and r6 busy, assert flush.
  - Required: busy_vec=0 and rd_busy=0 next cycle; err is unchanged.
  - A reset during flush gives the same result with err=0.
